// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Shared types and constants for the barycentric attribute interpolator.
//   argb_t   : ARGB8888 colour, alpha in the most significant byte
//   state_t  : interpolator sequencing states
//   ONE_Q    : 1.0 in unsigned Q0.POINT_WIDTH
// -----------------------------------------------------------------------------
package gfx_pkg;

    localparam int POINT_WIDTH = 16;
    localparam int COLOR_WIDTH = 32;
    localparam int CHANNELS    = 4;

    localparam logic [POINT_WIDTH:0] ONE_Q = (POINT_WIDTH + 1)'(1) << POINT_WIDTH;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } argb_t;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        WRITE,
        WAIT
    } state_t;

endpackage

// File: rtl/gfx_attr_mac.sv
// -----------------------------------------------------------------------------
// gfx_attr_mac
// One-channel multiply-accumulate with round-to-nearest and saturation.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr          : zero the accumulator (takes priority over en)
//   en           : add a * b into the accumulator this cycle
//   a            : attribute operand (colour channel or depth)
//   b            : unsigned Q0.frac_width weight (may reach 1.0 or above)
//   result       : round/saturate of (accumulator + a * b), i.e. the value the
//                  accumulator would hold after this cycle's add
// -----------------------------------------------------------------------------
module gfx_attr_mac #(
    parameter int a_width    = 8,
    parameter int b_width    = 17,
    parameter int acc_width  = 26,
    parameter int frac_width = 16,
    parameter int out_width  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr,
    input  logic                 en,
    input  logic [a_width-1:0]   a,
    input  logic [b_width-1:0]   b,
    output logic [out_width-1:0] result
);

    localparam int prod_width = a_width + b_width;
    localparam logic [acc_width:0] half = (acc_width + 1)'(1) << (frac_width - 1);

    logic [prod_width-1:0] prod;
    logic [acc_width-1:0]  acc;
    logic [acc_width-1:0]  sum;
    logic [acc_width:0]    shifted;

    assign prod    = prod_width'(a) * prod_width'(b);
    assign sum     = acc + acc_width'(prod);
    // One extra bit so adding the rounding half can never wrap.
    assign shifted = ({1'b0, sum} + half) >> frac_width;
    assign result  = (|shifted[acc_width:out_width]) ? '1 : shifted[out_width-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/gfx_attr_interp.sv
// -----------------------------------------------------------------------------
// gfx_attr_interp
// Per-pixel barycentric interpolator: f2 = 1 - f0 - f1 (saturating at 0),
// blends three ARGB8888 vertex colours and three depths over three MAC cycles,
// then presents one fragment with a write/ack handshake.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   write_i / ack_o        : pixel strobe in, one-cycle "pixel consumed" pulse out
//   factor0_i, factor1_i   : Q0.point_width weights of vertices 0 and 1
//   x_i, y_i               : raster position
//   color0_i..color2_i     : vertex colours
//   z0_i..z2_i             : vertex depths
//   color_en_i, z_en_i     : 1 = interpolate, 0 = pass vertex 0 value
//   write_o / ack_i        : one-cycle fragment strobe out, acknowledge in
//   x_o, y_o, color_o, z_o : fragment (held until the next fragment)
// -----------------------------------------------------------------------------
module gfx_attr_interp
    import gfx_pkg::*;
#(
    parameter int point_width = POINT_WIDTH,
    parameter int color_width = COLOR_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   write_i,
    output logic                   ack_o,
    input  logic [point_width-1:0] factor0_i,
    input  logic [point_width-1:0] factor1_i,
    input  logic [point_width-1:0] x_i,
    input  logic [point_width-1:0] y_i,
    input  logic [color_width-1:0] color0_i,
    input  logic [color_width-1:0] color1_i,
    input  logic [color_width-1:0] color2_i,
    input  logic [point_width-1:0] z0_i,
    input  logic [point_width-1:0] z1_i,
    input  logic [point_width-1:0] z2_i,
    input  logic                   color_en_i,
    input  logic                   z_en_i,
    output logic                   write_o,
    input  logic                   ack_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [color_width-1:0] color_o,
    output logic [point_width-1:0] z_o
);

    localparam int PW = point_width;
    localparam logic [PW:0] one_q = (PW + 1)'(1) << PW;

    state_t        state;
    logic [PW-1:0] f0, f1, x, y, z0, z1, z2;
    logic [PW:0]   f2;
    argb_t         col0, col1, col2;
    logic          color_en, z_en;

    logic [PW:0]   sum_f, f2_next;
    logic [PW:0]   op_factor;
    argb_t         op_color;
    logic [PW-1:0] op_z;
    logic          mac_clr, mac_en;
    logic [31:0]   blended;
    logic [PW-1:0] z_res;

    // f0 + f1 needs pw+1 bits; anything above 1.0 leaves no weight for vertex 2.
    assign sum_f   = {1'b0, factor0_i} + {1'b0, factor1_i};
    assign f2_next = (sum_f <= one_q) ? (one_q - sum_f) : '0;

    // Accumulators are cleared every idle cycle, so each pixel starts from zero.
    assign mac_clr = (state == IDLE);
    assign mac_en  = (state == MAC0) || (state == MAC1) || (state == MAC2);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_factor = '0;
        op_color  = '0;
        op_z      = '0;
        case (state)
            MAC0: begin
                op_factor = {1'b0, f0};
                op_color  = col0;
                op_z      = z0;
            end
            MAC1: begin
                op_factor = {1'b0, f1};
                op_color  = col1;
                op_z      = z1;
            end
            MAC2: begin
                op_factor = f2;
                op_color  = col2;
                op_z      = z2;
            end
            default: ;
        endcase
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        gfx_attr_mac #(
            .a_width   (8),
            .b_width   (PW + 1),
            .acc_width (8 + PW + 2),
            .frac_width(PW),
            .out_width (8)
        ) u_mac (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr   (mac_clr),
            .en    (mac_en),
            .a     (op_color[8*ch +: 8]),
            .b     (op_factor),
            .result(blended[8*ch +: 8])
        );
    end

    gfx_attr_mac #(
        .a_width   (PW),
        .b_width   (PW + 1),
        .acc_width (2*PW + 2),
        .frac_width(PW),
        .out_width (PW)
    ) u_mac_z (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (op_z),
        .b     (op_factor),
        .result(z_res)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the input latches are plain registers, not a memory, so they
            // are reset along with the outputs at negligible cost.
            state    <= IDLE;
            write_o  <= 1'b0;
            ack_o    <= 1'b0;
            x_o      <= '0;
            y_o      <= '0;
            color_o  <= '0;
            z_o      <= '0;
            f0       <= '0;
            f1       <= '0;
            f2       <= '0;
            x        <= '0;
            y        <= '0;
            z0       <= '0;
            z1       <= '0;
            z2       <= '0;
            col0     <= '0;
            col1     <= '0;
            col2     <= '0;
            color_en <= 1'b0;
            z_en     <= 1'b0;
        end else begin
            write_o <= 1'b0;
            ack_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        f0       <= factor0_i;
                        f1       <= factor1_i;
                        f2       <= f2_next;
                        x        <= x_i;
                        y        <= y_i;
                        col0     <= color0_i;
                        col1     <= color1_i;
                        col2     <= color2_i;
                        z0       <= z0_i;
                        z1       <= z1_i;
                        z2       <= z2_i;
                        color_en <= color_en_i;
                        z_en     <= z_en_i;
                        state    <= MAC0;
                    end
                end
                MAC0: state <= MAC1;
                MAC1: state <= MAC2;
                MAC2: begin
                    // MAC results already include vertex 2's product this cycle.
                    x_o     <= x;
                    y_o     <= y;
                    color_o <= color_en ? blended : col0;
                    z_o     <= z_en ? z_res : z0;
                    write_o <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (ack_i) begin
                        ack_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_i) begin
                        ack_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_attr_interp.sv
// -----------------------------------------------------------------------------
// tb_gfx_attr_interp
// Directed and randomized pixels against an arithmetic reference model of the
// barycentric blend (f2 = 1 - f0 - f1 saturating at 0, round-to-nearest,
// saturate to channel maximum).
// -----------------------------------------------------------------------------
module tb_gfx_attr_interp;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_i = 1'b0;
    logic          ack_o;
    logic [PW-1:0] factor0_i = '0, factor1_i = '0, x_i = '0, y_i = '0;
    logic [31:0]   color0_i = '0, color1_i = '0, color2_i = '0;
    logic [PW-1:0] z0_i = '0, z1_i = '0, z2_i = '0;
    logic          color_en_i = 1'b0, z_en_i = 1'b0;
    logic          write_o;
    logic          ack_i = 1'b0;
    logic [PW-1:0] x_o, y_o, z_o;
    logic [31:0]   color_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gfx_attr_interp #(.point_width(PW), .color_width(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .write_i   (write_i),
        .ack_o     (ack_o),
        .factor0_i (factor0_i),
        .factor1_i (factor1_i),
        .x_i       (x_i),
        .y_i       (y_i),
        .color0_i  (color0_i),
        .color1_i  (color1_i),
        .color2_i  (color2_i),
        .z0_i      (z0_i),
        .z1_i      (z1_i),
        .z2_i      (z2_i),
        .color_en_i(color_en_i),
        .z_en_i    (z_en_i),
        .write_o   (write_o),
        .ack_i     (ack_i),
        .x_o       (x_o),
        .y_o       (y_o),
        .color_o   (color_o),
        .z_o       (z_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Weighted sum with 1.0 = 65536, rounded to nearest, clamped to maxv.
    function automatic longint unsigned blend(input longint unsigned v0, input longint unsigned v1,
                                              input longint unsigned v2, input longint unsigned w0,
                                              input longint unsigned w1, input longint unsigned maxv);
        longint unsigned s, w2, acc, r;
        s   = w0 + w1;
        w2  = (s <= 65536) ? 65536 - s : 0;
        acc = v0 * w0 + v1 * w1 + v2 * w2;
        r   = (acc + 32768) / 65536;
        return (r > maxv) ? maxv : r;
    endfunction

    function automatic logic [31:0] exp_color(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [15:0] w0,
                                              input logic [15:0] w1, input logic en);
        logic [31:0] res;
        res = c0;
        if (en) begin
            for (int ch = 0; ch < 4; ch++) begin
                res[8*ch +: 8] = 8'(blend((c0 >> (8*ch)) & 255, (c1 >> (8*ch)) & 255,
                                          (c2 >> (8*ch)) & 255, w0, w1, 255));
            end
        end
        return res;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_write_o"}, 64'(write_o), 64'd0);
        chk({tag, "_ack_o"},   64'(ack_o),   64'd0);
        chk({tag, "_x_o"},     64'(x_o),     64'd0);
        chk({tag, "_y_o"},     64'(y_o),     64'd0);
        chk({tag, "_color_o"}, 64'(color_o), 64'd0);
        chk({tag, "_z_o"},     64'(z_o),     64'd0);
    endtask

    // Called at a falling edge; drives write_i in the current cycle and returns
    // at the falling edge where ack_o should be high.
    task automatic run_pixel(input string tag, input logic [15:0] f0, input logic [15:0] f1,
                             input logic [15:0] x, input logic [15:0] y,
                             input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                             input logic [15:0] z0, input logic [15:0] z1, input logic [15:0] z2,
                             input logic cen, input logic zen, input int ack_wait, input logic noise);
        logic [31:0] ec;
        logic [15:0] ez;
        int lat;
        ec = exp_color(c0, c1, c2, f0, f1, cen);
        ez = zen ? 16'(blend(z0, z1, z2, f0, f1, 65535)) : z0;
        factor0_i = f0; factor1_i = f1; x_i = x; y_i = y;
        color0_i = c0; color1_i = c1; color2_i = c2;
        z0_i = z0; z1_i = z1; z2_i = z2;
        color_en_i = cen; z_en_i = zen;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        lat = 1;
        if (noise) ack_i = 1'b1;
        while (write_o !== 1'b1 && lat < 20) begin
            if (noise && lat == 2) begin
                // Illegal mid-pixel strobe with different data must be ignored.
                write_i   = 1'b1;
                factor0_i = 16'($urandom);
                factor1_i = 16'($urandom);
                x_i       = 16'($urandom);
                color0_i  = $urandom;
                z0_i      = 16'($urandom);
            end
            @(negedge clk);
            write_i = 1'b0;
            lat++;
        end
        ack_i = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_ack_idle"}, 64'(ack_o), 64'd0);
        chk({tag, "_x"}, 64'(x_o), 64'(x));
        chk({tag, "_y"}, 64'(y_o), 64'(y));
        chk({tag, "_color"}, 64'(color_o), 64'(ec));
        chk({tag, "_z"}, 64'(z_o), 64'(ez));
        if (ack_wait == 0) begin
            ack_i = 1'b1;
        end else begin
            for (int k = 0; k < ack_wait; k++) begin
                @(negedge clk);
                chk({tag, "_stall_write"}, 64'(write_o), 64'd0);
                chk({tag, "_stall_ack"}, 64'(ack_o), 64'd0);
                chk({tag, "_stall_color"}, 64'(color_o), 64'(ec));
            end
            ack_i = 1'b1;
        end
        @(negedge clk);
        ack_i = 1'b0;
        chk({tag, "_ack_o"}, 64'(ack_o), 64'd1);
        chk({tag, "_write_low"}, 64'(write_o), 64'd0);
    endtask

    initial begin
        logic [15:0] rf0, rf1;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1 Blend
        run_pixel("blend", 16'h8000, 16'h4000, 16'h0012, 16'h0034,
                  32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                  16'h1000, 16'h2000, 16'h3000, 1'b1, 1'b1, 1, 1'b0);
        chk("blend_color_lit", 64'(color_o), 64'h00804040);
        chk("blend_z_lit", 64'(z_o), 64'h1C00);

        // 2 Factor saturation, back-to-back
        run_pixel("fsat", 16'hFFFF, 16'h0002, 16'h0001, 16'h0002,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                  16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        chk("fsat_color_lit", 64'(color_o), 64'hFFFFFFFF);
        run_pixel("white", 16'hFFFF, 16'h0000, 16'h0003, 16'h0004,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b1, 2, 1'b0);
        chk("white_color_lit", 64'(color_o), 64'hFFFFFFFF);

        // 3 Flat shading
        run_pixel("flat", 16'h8000, 16'h4000, 16'h0055, 16'h0066,
                  32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                  16'h1000, 16'h2000, 16'h3000, 1'b0, 1'b0, 0, 1'b0);
        chk("flat_color_lit", 64'(color_o), 64'h00FF0000);
        chk("flat_z_lit", 64'(z_o), 64'h1000);

        // 4 Backpressure, with spurious ack_i and write_i during the MAC cycles
        run_pixel("bp", 16'h8000, 16'h4000, 16'h0077, 16'h0088,
                  32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                  16'h1000, 16'h2000, 16'h3000, 1'b1, 1'b1, 10, 1'b1);

        // 6 Reset in MAC1
        factor0_i = 16'h2000; factor1_i = 16'h2000; x_i = 16'h0AAA; y_i = 16'h0BBB;
        color_en_i = 1'b1; z_en_i = 1'b1;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero_outputs("rst_mac1");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_write", 64'(write_o), 64'd0);
            chk("post_rst_ack", 64'(ack_o), 64'd0);
        end
        run_pixel("after_rst", 16'h1234, 16'h5678, 16'h0101, 16'h0202,
                  32'h80402010, 32'h11223344, 32'hAABBCCDD,
                  16'h4000, 16'h8000, 16'hC000, 1'b1, 1'b1, 1, 1'b0);

        // 5 Back-to-back randomized pixels
        for (int i = 0; i < 24; i++) begin
            rf0 = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                rf1 = 16'($urandom_range(0, 65536 - int'(rf0) > 65535 ? 65535 : 65536 - int'(rf0)));
            else
                rf1 = 16'($urandom);
            run_pixel("rand", rf0, rf1, 16'($urandom), 16'($urandom),
                      $urandom, $urandom, $urandom,
                      16'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
